// File: rtl/lc_mem_arbiter.sv
// Two-port arbiter that shares one layer-controller memory port between the
// MBus memory interface (port 0) and a local master (port 1). It runs one memory
// transaction at a time, uses four-phase REQ/ACK handshakes on every side,
// grants round-robin under contention and aborts transactions that the memory
// never acknowledges.
module lc_mem_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64,
  parameter int TO_W    = 7
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              P0_REQ,
  input  logic              P0_WRITE,
  input  logic [ADDR_W-1:0] P0_ADDR,
  input  logic [DATA_W-1:0] P0_WDATA,
  output logic              P0_ACK,
  input  logic              P1_REQ,
  input  logic              P1_WRITE,
  input  logic [ADDR_W-1:0] P1_ADDR,
  input  logic [DATA_W-1:0] P1_WDATA,
  output logic              P1_ACK,
  output logic [DATA_W-1:0] RDATA,
  output logic              ERR,
  output logic              MEM_REQ_OUT,
  output logic              MEM_WRITE,
  output logic [ADDR_W-1:0] MEM_AOUT,
  output logic [DATA_W-1:0] MEM_DOUT,
  input  logic              MEM_ACK_IN,
  input  logic [DATA_W-1:0] MEM_DIN,
  output logic [7:0]        TO_COUNT
);

  typedef enum logic [1:0] {
    IDLE,
    MEM_BUSY,
    MEM_RELEASE,
    RESP
  } state_t;

  state_t            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              grant_id_q, grant_id_d;
  logic [TO_W-1:0]   timer_q, timer_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_aout_q, mem_aout_d;
  logic [DATA_W-1:0] mem_dout_q, mem_dout_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              p0_ack_q, p0_ack_d;
  logic              p1_ack_q, p1_ack_d;
  logic [7:0]        to_count_q, to_count_d;
  logic              grant_sel;
  logic              granted_req;

  // Next-state logic: arbitration, memory sequencing, timeout abort and the
  // requester-side handshake. Every output is a flop, so everything is computed here.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    timer_d      = timer_q;
    mem_req_d    = mem_req_q;
    mem_write_d  = mem_write_q;
    mem_aout_d   = mem_aout_q;
    mem_dout_d   = mem_dout_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    p0_ack_d     = p0_ack_q;
    p1_ack_d     = p1_ack_q;
    to_count_d   = to_count_q;
    grant_sel    = 1'b0;
    granted_req  = grant_id_q ? P1_REQ : P0_REQ;

    case (state_q)
      IDLE: begin
        if (P0_REQ || P1_REQ) begin
          grant_sel    = (P0_REQ && P1_REQ) ? ~last_grant_q : P1_REQ;
          grant_id_d   = grant_sel;
          last_grant_d = grant_sel;
          mem_aout_d   = grant_sel ? P1_ADDR  : P0_ADDR;
          mem_dout_d   = grant_sel ? P1_WDATA : P0_WDATA;
          mem_write_d  = grant_sel ? P1_WRITE : P0_WRITE;
          mem_req_d    = 1'b1;
          timer_d      = '0;
          err_d        = 1'b0;
          state_d      = MEM_BUSY;
        end
      end

      MEM_BUSY: begin
        if (MEM_ACK_IN) begin
          if (!mem_write_q) begin
            rdata_d = MEM_DIN;
          end
          mem_req_d   = 1'b0;
          mem_write_d = 1'b0;
          state_d     = MEM_RELEASE;
        end else if (timer_q == TO_W'(TIMEOUT - 1)) begin
          mem_req_d   = 1'b0;
          mem_write_d = 1'b0;
          err_d       = 1'b1;
          if (to_count_q != 8'hFF) begin
            to_count_d = to_count_q + 8'd1;
          end
          state_d     = MEM_RELEASE;
        end else begin
          timer_d = timer_q + TO_W'(1);
        end
      end

      MEM_RELEASE: begin
        if (!MEM_ACK_IN) begin
          p0_ack_d = ~grant_id_q;
          p1_ack_d = grant_id_q;
          state_d  = RESP;
        end
      end

      RESP: begin
        if (!granted_req) begin
          p0_ack_d = 1'b0;
          p1_ack_d = 1'b0;
          state_d  = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset clears everything and favours port 0 first.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      grant_id_q   <= 1'b0;
      timer_q      <= '0;
      mem_req_q    <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_aout_q   <= '0;
      mem_dout_q   <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      p0_ack_q     <= 1'b0;
      p1_ack_q     <= 1'b0;
      to_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      timer_q      <= timer_d;
      mem_req_q    <= mem_req_d;
      mem_write_q  <= mem_write_d;
      mem_aout_q   <= mem_aout_d;
      mem_dout_q   <= mem_dout_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      p0_ack_q     <= p0_ack_d;
      p1_ack_q     <= p1_ack_d;
      to_count_q   <= to_count_d;
    end
  end

  assign P0_ACK      = p0_ack_q;
  assign P1_ACK      = p1_ack_q;
  assign RDATA       = rdata_q;
  assign ERR         = err_q;
  assign MEM_REQ_OUT = mem_req_q;
  assign MEM_WRITE   = mem_write_q;
  assign MEM_AOUT    = mem_aout_q;
  assign MEM_DOUT    = mem_dout_q;
  assign TO_COUNT    = to_count_q;

endmodule

// File: doc/lc_mem_arbiter.md
Name: lc_mem_arbiter

Overview:
- Two-port arbiter sharing one layer-controller memory port between two masters:
  - Port 0: the layer controller's MBus-driven memory interface.
  - Port 1: a local master, e.g. a CPU or DMA engine.
- Sits between the masters and the memory macro.
- Sequences one memory transaction at a time, with a four-phase REQ/ACK handshake on every side.
- Arbitrates round-robin and aborts transactions the memory never acknowledges.

Parameters:
- ADDR_W, 8, memory word-address width (LC_MEM_ADDR_WIDTH).
- DATA_W, 32, memory data width (LC_MEM_DATA_WIDTH).
- TIMEOUT, 64, cycles to wait for MEM_ACK_IN before aborting; must be >= 2.
- TO_W, 7, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT.

Ports:
- CLK  in  1  clock.
- RESET  in  1  synchronous active-high reset.
- P0_REQ  in  1  port-0 request; held until P0_ACK.
- P0_WRITE  in  1  port-0: 1 = write, 0 = read.
- P0_ADDR  in  ADDR_W  port-0 address.
- P0_WDATA  in  DATA_W  port-0 write data.
- P0_ACK  out  1  port-0 completion.
- P1_REQ, P1_WRITE, P1_ADDR, P1_WDATA, P1_ACK: as for port 0.
- RDATA  out  DATA_W  read data; valid while the granted port's ACK is high.
- ERR  out  1  completion was a timeout abort; valid with ACK.
- MEM_REQ_OUT  out  1  memory request.
- MEM_WRITE  out  1  memory write strobe.
- MEM_AOUT  out  ADDR_W  memory address.
- MEM_DOUT  out  DATA_W  memory write data.
- MEM_ACK_IN  in  1  memory acknowledge.
- MEM_DIN  in  DATA_W  memory read data.
- TO_COUNT  out  8  saturating count of timeout aborts.

Behaviour:
- All outputs are registered. State, counters and outputs change only on the CLK rising edge.
- Reset:
  - RESET=1 at an edge clears everything to 0, including MEM_AOUT, MEM_DOUT, RDATA and TO_COUNT.
  - State returns to IDLE and last_grant is set to 1, so port 0 wins first.
  - Reset mid-transaction drops MEM_REQ_OUT and the ACKs on that edge. No completion is reported.
- IDLE:
  - One requester: grant it.
  - Both requesting: grant the port opposite last_grant.
  - On a grant, on the same edge:
    - latch the port's ADDR/WDATA/WRITE into MEM_AOUT/MEM_DOUT/MEM_WRITE;
    - set MEM_REQ_OUT=1;
    - update last_grant and grant_id;
    - clear the timer and ERR.
  - Go to MEM_BUSY. Latency: REQ sampled at edge N gives MEM_REQ_OUT high after edge N.
- MEM_BUSY:
  - MEM_ACK_IN=1: RDATA<=MEM_DIN if a read (unchanged on a write); MEM_REQ_OUT<=0; MEM_WRITE<=0; go to MEM_RELEASE.
  - Otherwise the timer increments. When timer == TIMEOUT-1: MEM_REQ_OUT<=0, MEM_WRITE<=0, ERR<=1, TO_COUNT increments (saturating at 255), go to MEM_RELEASE. RDATA is unchanged on an abort.
  - ACK wins if it arrives on the timeout cycle.
- MEM_RELEASE:
  - Wait for MEM_ACK_IN=0, which covers memory that acknowledges late after an abort.
  - Then assert the granted port's ACK and go to RESP.
- RESP:
  - Hold ACK, RDATA and ERR.
  - When the granted REQ=0: drop ACK and go to IDLE.
  - Completion semantics: a read returns the RDATA latched in MEM_BUSY; a write completes without updating RDATA.
  - A new grant is possible on the next edge, so a request-to-request gap is at least one IDLE cycle.
- Handshake rules:
  - The non-granted port's REQ is ignored until IDLE; its ACK stays 0.
  - Changes to the granted port's inputs after the grant are ignored (latched).
  - A requester deasserting REQ before ACK is a protocol violation. The transaction completes anyway, and ACK pulses for exactly one cycle because REQ is already low in RESP.
- Fairness: under continuous contention, grants alternate 0,1,0,1.
- MEM_REQ_OUT and an ACK are never high in the same cycle.

Test Plan:
- P0 read, ADDR=0x10, memory returns 0xDEADBEEF after 3 cycles:
  - MEM_REQ_OUT rises 1 cycle after REQ, with MEM_AOUT=0x10 and MEM_WRITE=0;
  - P0_ACK=1 with RDATA=0xDEADBEEF and ERR=0;
  - ACK drops 1 cycle after REQ drops.
- P1 write, ADDR=0x22, WDATA=0x12345678: MEM_WRITE=1 and MEM_DOUT=0x12345678 while MEM_REQ_OUT is high; P1_ACK follows; RDATA is unchanged.
- P0 and P1 requesting from reset and re-requesting immediately, 4 transactions: grant order 0,1,0,1; P1_ACK never asserts during a P0 transaction.
- Memory never acks, TIMEOUT=64:
  - MEM_REQ_OUT drops exactly 64 cycles after rising;
  - ACK asserts with ERR=1 and TO_COUNT=1;
  - a late MEM_ACK_IN pulse delays ACK until it falls.
- RESET asserted while in MEM_BUSY: all outputs 0 on the next edge; a subsequent P1 request is granted normally.
- 256 forced timeouts: TO_COUNT saturates at 255.
